add_aligner: RTL



---
 rtl/add_aligner.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/add_aligner.sv
// add_aligner: front end of the FP16 adder.
//
// Unpacks two IEEE-754 half-precision operands, orders them by magnitude,
// right-aligns the smaller mantissa to the larger exponent and performs one
// add/subtract. The normalizer stage downstream receives an unnormalized result.
//
// Build option:
//   ALIGN_BARREL_EN - when defined, the alignment finishes in a single cycle
//                     through a barrel shifter. When undefined, the mantissa
//                     shifts one bit per cycle. Results are identical.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   in_valid     operand pair valid
//   in_ready     block can accept operands (high only in idle)
//   op_a, op_b   FP16 operands
//   out_valid    result valid, held until out_ready
//   out_ready    downstream accepts the result
//   sign         result sign
//   exponent     larger operand's exponent (pre-normalization)
//   mantissa_add unnormalized 11-bit mantissa
//   if_sub       1: leading-zero normalize path, 0: increment-exponent path
//   out_zero     exact zero result
module add_aligner #(
  parameter int unsigned MAX_SHIFT = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign,
  output logic [4:0]  exponent,
  output logic [10:0] mantissa_add,
  output logic        if_sub,
  output logic        out_zero
);

  typedef enum logic [1:0] {StIdle, StAlign, StAdd, StHold} state_e;

  state_e      state_q, state_d;
  logic [10:0] big_q, big_d;
  logic [10:0] small_q, small_d;
  logic [4:0]  exp_big_q, exp_big_d;
  logic        sign_big_q, sign_big_d;
  logic        eff_sub_q, eff_sub_d;
  logic [4:0]  cnt_q, cnt_d;

  logic        sign_q, sign_d;
  logic [4:0]  exponent_q, exponent_d;
  logic [10:0] mant_q, mant_d;
  logic        if_sub_q, if_sub_d;
  logic        zero_q, zero_d;
  logic        valid_q, valid_d;

  // Unpack: a zero exponent is treated as zero, so the mantissa is dropped.
  logic [10:0] mant_a, mant_b;
  logic        a_big;
  logic [4:0]  exp_big_in, exp_small_in, exp_diff;
  logic        flush;

  assign mant_a = (op_a[14:10] != 5'd0) ? {1'b1, op_a[9:0]} : 11'd0;
  assign mant_b = (op_b[14:10] != 5'd0) ? {1'b1, op_b[9:0]} : 11'd0;

  // Comparing {exp,frac} orders by magnitude; ties keep A as the big operand.
  assign a_big        = op_a[14:0] >= op_b[14:0];
  assign exp_big_in   = a_big ? op_a[14:10] : op_b[14:10];
  assign exp_small_in = a_big ? op_b[14:10] : op_a[14:10];
  assign exp_diff     = exp_big_in - exp_small_in;
  assign flush        = {27'd0, exp_diff} >= MAX_SHIFT;

  // Add/subtract on the aligned mantissas. The big operand is never smaller
  // than the aligned small one, so the difference cannot go negative.
  logic [11:0] sum;
  logic [10:0] diff_mant;
  logic [10:0] res_mant;
  logic        res_sub;
  logic        res_zero;

  assign sum       = {1'b0, big_q} + {1'b0, small_q};
  assign diff_mant = big_q - small_q;

  always_comb begin
    res_mant = 11'd0;
    res_sub  = 1'b1;
    if (eff_sub_q) begin
      res_mant = diff_mant;
      res_sub  = 1'b1;
    end else if (sum[11]) begin
      // Carry out: keep the top 11 bits, normalizer bumps the exponent.
      res_mant = sum[11:1];
      res_sub  = 1'b0;
    end else begin
      res_mant = sum[10:0];
      res_sub  = 1'b1;
    end
  end

  assign res_zero = (res_mant == 11'd0);

  always_comb begin
    state_d    = state_q;
    big_d      = big_q;
    small_d    = small_q;
    exp_big_d  = exp_big_q;
    sign_big_d = sign_big_q;
    eff_sub_d  = eff_sub_q;
    cnt_d      = cnt_q;
    sign_d     = sign_q;
    exponent_d = exponent_q;
    mant_d     = mant_q;
    if_sub_d   = if_sub_q;
    zero_d     = zero_q;
    valid_d    = valid_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          big_d      = a_big ? mant_a : mant_b;
          small_d    = flush ? 11'd0 : (a_big ? mant_b : mant_a);
          cnt_d      = flush ? 5'd0 : exp_diff;
          exp_big_d  = exp_big_in;
          sign_big_d = a_big ? op_a[15] : op_b[15];
          eff_sub_d  = op_a[15] ^ op_b[15];
          state_d    = StAlign;
        end
      end
      StAlign: begin
`ifdef ALIGN_BARREL_EN
        small_d = small_q >> cnt_q;
        cnt_d   = 5'd0;
        state_d = StAdd;
`else
        if (cnt_q == 5'd0) begin
          state_d = StAdd;
        end else begin
          small_d = small_q >> 1;
          cnt_d   = cnt_q - 5'd1;
        end
`endif
      end
      StAdd: begin
        sign_d     = res_zero ? 1'b0 : sign_big_q;
        exponent_d = res_zero ? 5'd0 : exp_big_q;
        mant_d     = res_mant;
        if_sub_d   = res_sub;
        zero_d     = res_zero;
        valid_d    = 1'b1;
        state_d    = StHold;
      end
      StHold: begin
        if (out_ready) begin
          valid_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      big_q      <= 11'd0;
      small_q    <= 11'd0;
      exp_big_q  <= 5'd0;
      sign_big_q <= 1'b0;
      eff_sub_q  <= 1'b0;
      cnt_q      <= 5'd0;
      sign_q     <= 1'b0;
      exponent_q <= 5'd0;
      mant_q     <= 11'd0;
      if_sub_q   <= 1'b0;
      zero_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      big_q      <= big_d;
      small_q    <= small_d;
      exp_big_q  <= exp_big_d;
      sign_big_q <= sign_big_d;
      eff_sub_q  <= eff_sub_d;
      cnt_q      <= cnt_d;
      sign_q     <= sign_d;
      exponent_q <= exponent_d;
      mant_q     <= mant_d;
      if_sub_q   <= if_sub_d;
      zero_q     <= zero_d;
      valid_q    <= valid_d;
    end
  end

  assign in_ready     = (state_q == StIdle);
  assign out_valid    = valid_q;
  assign sign         = sign_q;
  assign exponent     = exponent_q;
  assign mantissa_add = mant_q;
  assign if_sub       = if_sub_q;
  assign out_zero     = zero_q;

endmodule
